framebuffer_scanout: RTL and testbench
======================================

// Module: framebuffer_scanout
// PURPOSE
//   Reader end of the frame-buffer write port: generates 640x480@60 VGA timing, reads one
//   6-bit colour per pixel from the frame buffer and drives the VGA DAC. Exports vga_active
//   so the map renderer writes the buffer only while the scan is outside the visible area.
// PARAMETERS
//   SCREEN_WIDTH   640  visible pixels per line
//   SCREEN_HEIGHT  480  visible lines per frame
//   H_FRONT 16, H_SYNC 96, H_BACK 48   horizontal porch/sync widths (pixels)
//   V_FRONT 10, V_SYNC 2,  V_BACK 33   vertical porch/sync widths (lines)
//   CLK_DIV        2    clk cycles per pixel tick; must be >=2
// PORTS
//   clk          in   1   system clock (50 MHz)
//   rst_n        in   1   asynchronous reset, active low
//   buffer_x     out  10  pixel column being fetched
//   buffer_y     out  10  pixel row being fetched
//   buffer_read  out  1   read strobe, one clk wide
//   buffer_cor   in   6   {R[1:0],G[1:0],B[1:0]}, valid exactly 1 clk after buffer_read
//   vga_active   out  1   1 while counters are inside the visible area
//   frame_end    out  1   one-clk pulse when the counters enter line SCREEN_HEIGHT
//   vga_r/g/b    out  8   colour per channel (each 8 bits)
//   vga_hsync    out  1   active low;   vga_vsync  out 1  active low
//   vga_blank_n  out  1   0 outside the visible area;   vga_clk  out 1  pixel tick clock
// BEHAVIOUR
// - Divider counts 0..CLK_DIV-1. tick = (div==CLK_DIV-1). vga_clk = div < CLK_DIV/2.
// - Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance on tick.
//   H_TOTAL = sum of H params = 800; V_TOTAL = 525.
//   h wraps to 0 and increments v; v wraps to 0 after V_TOTAL-1.
// - Fetch stage (on tick, counters at (h,v)):
//   - Visible (h<W && v<H): buffer_x=h, buffer_y=v, buffer_read=1 for that clk only.
//   - Otherwise buffer_read=0; x/y hold their last values.
// - Data stage: buffer_cor is captured on the clk after buffer_read into a pixel register.
// - Output stage (next tick): outputs reflect the pixel fetched on the previous tick.
//   - Latency is exactly 1 pixel tick from fetch to DAC.
//   - hsync, vsync, blank_n and colour are all delayed by that same tick, so they stay aligned.
// - Colour expansion: 2-bit channel c -> {c,c,c,c}
//   - 00->00, 01->55, 10->AA, 11->FF.
//   - Non-visible pixels output 0.
// - hsync=0 for output h in [W+H_FRONT, W+H_FRONT+H_SYNC) = [656,752).
// - vsync=0 for output v in [490,492).
// - vga_active is registered from the counters with no delay. It falls on the tick h becomes
//   640 and rises at h=0 of lines 0..479.
// - frame_end=1 for the single clk of the tick on which (h,v) becomes (0,480).
// - Reset (any time, including mid-line):
//   - Divider, h, v, buffer_x/y, buffer_read, colour, vga_active and frame_end all go to 0.
//   - hsync=vsync=1, blank_n=0.
//   - The first tick after release fetches (0,0). No partial-frame state survives.
// - A buffer_cor arriving on a clk without a preceding buffer_read is ignored.
// CONFIGURATION
//   TEST_PATTERN_EN defined:
//   - Adds input test_mode (1 bit).
//   - When test_mode=1: buffer_read is held 0 and the output pixel comes from a colour bar.
//     - bar = h/80 (0..7); colour = {bar[2],bar[2],bar[1],bar[1],bar[0],bar[0]}, expanded as above.
//     - Sync, blanking and latency are unchanged.
//   - test_mode is sampled only at the frame boundary (h=0,v=0), so no frame is split.
//   TEST_PATTERN_EN undefined: no test_mode port; the buffer is always the pixel source.
// TESTING
// 1. rst_n low for 3 clk mid-line (h=300,v=100):
//    outputs go to reset values asynchronously; the first buffer_read after release has x=0,y=0.
// 2. Run 1 line:
//    - buffer_read pulses 640 times, x=0..639 with y constant.
//    - No reads for h in 640..799; y increments to 1 on the next line.
// 3. buffer_cor=6'b110000 for fetch (5,3): vga_r=FF, g=00, b=00, blank_n=1 one tick later.
//    buffer_cor=6'b011011: r=55, g=AA, b=FF.
// 4. Full frame at CLK_DIV=2:
//    - Period is 840000 clk; hsync low 96 ticks per line; vsync low exactly 2 lines.
//    - 307200 reads per frame.
// 5. Check vga_active and frame_end:
//    - vga_active high 640 ticks per line for lines 0..479, low through vblank.
//    - frame_end pulses once per frame, 1 clk wide.
// 6. TEST_PATTERN_EN, test_mode=1 at frame start:
//    - buffer_read stays 0 all frame; pixel 0-79 black, 80-159 blue (b=FF),
//      560-639 white (FF/FF/FF).

Source files
------------

// File: rtl/framebuffer_scanout.sv
// 640x480@60 VGA scan-out: timing generator, frame-buffer fetch and DAC drive with one-tick latency.
// Optional colour-bar source is enabled by defining TEST_PATTERN_EN (adds input i_test_mode).
module framebuffer_scanout #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned H_FRONT       = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BACK        = 48,
  parameter int unsigned V_FRONT       = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BACK        = 33,
  parameter int unsigned CLK_DIV       = 2,
  localparam int unsigned CW           = 10,
  localparam int unsigned PW           = 6,
  localparam int unsigned DACW         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef TEST_PATTERN_EN
  input  logic            i_test_mode,
`endif
  output logic [CW-1:0]   o_buffer_x,
  output logic [CW-1:0]   o_buffer_y,
  output logic            o_buffer_read,
  input  logic [PW-1:0]   i_buffer_cor,
  output logic            o_vga_active,
  output logic            o_frame_end,
  output logic [DACW-1:0] o_vga_r,
  output logic [DACW-1:0] o_vga_g,
  output logic [DACW-1:0] o_vga_b,
  output logic            o_vga_hsync,
  output logic            o_vga_vsync,
  output logic            o_vga_blank_n,
  output logic            o_vga_clk
);

  localparam int unsigned H_TOTAL  = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = SCREEN_WIDTH + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = SCREEN_HEIGHT + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BAR_W    = SCREEN_WIDTH / 8;

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic          w_tick;
  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic [CW-1:0] w_h_nxt;
  logic [CW-1:0] w_v_nxt;
  logic          w_vis;
  logic          w_vis_nxt;
  logic          w_hs_in;
  logic          w_vs_in;
  logic [2:0]    w_bar;
  logic          w_test;

  logic          r_rd_d;
  logic [PW-1:0] r_pix;
  logic [PW-1:0] w_pix;
  logic [PW-1:0] w_src;
  logic          r_vis_d;
  logic          r_hs_d;
  logic          r_vs_d;
  logic          r_pat_d;
  logic [2:0]    r_bar_d;

  function automatic logic [DACW-1:0] expand(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  // Divider, counter advance and position decode of the fetch stage
  always_comb begin
    w_tick    = (r_div == DW'(CLK_DIV - 1));
    w_div_nxt = w_tick ? '0 : r_div + DW'(1);
    w_h_nxt   = r_h;
    w_v_nxt   = r_v;
    if (w_tick) begin
      if (r_h == CW'(H_TOTAL - 1)) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v == CW'(V_TOTAL - 1)) ? '0 : r_v + CW'(1);
      end else begin
        w_h_nxt = r_h + CW'(1);
      end
    end
    w_vis     = (r_h < CW'(SCREEN_WIDTH)) && (r_v < CW'(SCREEN_HEIGHT));
    w_vis_nxt = (w_h_nxt < CW'(SCREEN_WIDTH)) && (w_v_nxt < CW'(SCREEN_HEIGHT));
    w_hs_in   = (r_h >= CW'(HS_START)) && (r_h < CW'(HS_END));
    w_vs_in   = (r_v >= CW'(VS_START)) && (r_v < CW'(VS_END));
    w_bar     = 3'(r_h / CW'(BAR_W));
  end

`ifdef TEST_PATTERN_EN
  logic r_test;

  // Pattern selection only changes on the fetch of pixel (0,0) so a frame is never split
  assign w_test = (r_h == '0 && r_v == '0) ? i_test_mode : r_test;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_test <= 1'b0;
    end else if (w_tick) begin
      r_test <= w_test;
    end
  end
`else
  assign w_test = 1'b0;
`endif

  // Read data lands one clk after the strobe; on a divide-by-2 that is the output tick itself
  always_comb begin
    w_pix = r_rd_d ? i_buffer_cor : r_pix;
    w_src = r_pat_d ? {r_bar_d[2], r_bar_d[2], r_bar_d[1], r_bar_d[1], r_bar_d[0], r_bar_d[0]}
                    : w_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_rd_d        <= 1'b0;
      r_pix         <= '0;
      r_vis_d       <= 1'b0;
      r_hs_d        <= 1'b0;
      r_vs_d        <= 1'b0;
      r_pat_d       <= 1'b0;
      r_bar_d       <= '0;
      o_buffer_x    <= '0;
      o_buffer_y    <= '0;
      o_buffer_read <= 1'b0;
      o_vga_active  <= 1'b0;
      o_frame_end   <= 1'b0;
      o_vga_r       <= '0;
      o_vga_g       <= '0;
      o_vga_b       <= '0;
      o_vga_hsync   <= 1'b1;
      o_vga_vsync   <= 1'b1;
      o_vga_blank_n <= 1'b0;
      o_vga_clk     <= 1'b1;
    end else begin
      r_div         <= w_div_nxt;
      o_vga_clk     <= (w_div_nxt < DW'(CLK_DIV / 2));
      o_buffer_read <= 1'b0;
      o_frame_end   <= 1'b0;
      r_rd_d        <= o_buffer_read;
      if (r_rd_d) begin
        r_pix <= i_buffer_cor;
      end
      if (w_tick) begin
        r_h          <= w_h_nxt;
        r_v          <= w_v_nxt;
        o_vga_active <= w_vis_nxt;
        o_frame_end  <= (w_h_nxt == '0) && (w_v_nxt == CW'(SCREEN_HEIGHT));
        if (w_vis && !w_test) begin
          o_buffer_read <= 1'b1;
          o_buffer_x    <= r_h;
          o_buffer_y    <= r_v;
        end
        // Fetch-time attributes, replayed at the DAC on the following tick
        r_vis_d       <= w_vis;
        r_hs_d        <= w_hs_in;
        r_vs_d        <= w_vs_in;
        r_pat_d       <= w_test;
        r_bar_d       <= w_bar;
        o_vga_blank_n <= r_vis_d;
        o_vga_hsync   <= ~r_hs_d;
        o_vga_vsync   <= ~r_vs_d;
        o_vga_r       <= r_vis_d ? expand(w_src[5:4]) : '0;
        o_vga_g       <= r_vis_d ? expand(w_src[3:2]) : '0;
        o_vga_b       <= r_vis_d ? expand(w_src[1:0]) : '0;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench for framebuffer_scanout on a reduced raster, with a position/time based
// reference model, a random-data frame-buffer responder and hand sequences for reset and frame stats.
module tb_framebuffer_scanout;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int D  = 2;
  localparam int HT = W + HF + HS + HB;
  localparam int VT = H + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] cor = 6'd0;
  logic       test_mode = 1'b0;
  logic [9:0] o_buffer_x, o_buffer_y;
  logic       o_buffer_read, o_vga_active, o_frame_end;
  logic [7:0] o_vga_r, o_vga_g, o_vga_b;
  logic       o_vga_hsync, o_vga_vsync, o_vga_blank_n, o_vga_clk;

  framebuffer_scanout #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef TEST_PATTERN_EN
    .i_test_mode(test_mode),
`endif
    .o_buffer_x(o_buffer_x),
    .o_buffer_y(o_buffer_y),
    .o_buffer_read(o_buffer_read),
    .i_buffer_cor(cor),
    .o_vga_active(o_vga_active),
    .o_frame_end(o_frame_end),
    .o_vga_r(o_vga_r),
    .o_vga_g(o_vga_g),
    .o_vga_b(o_vga_b),
    .o_vga_hsync(o_vga_hsync),
    .o_vga_vsync(o_vga_vsync),
    .o_vga_blank_n(o_vga_blank_n),
    .o_vga_clk(o_vga_clk)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       rd;
    logic       act;
    logic       fe;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       vck;
  } out_t;

  typedef struct {
    logic [5:0] cor;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  int         n_checks = 0;
  int         n_fails  = 0;
  int         k = 0;
  int         cyc = 0;
  int         mx = 0;
  int         my = 0;
  logic       m_test = 1'b0;
  logic       pend = 1'b0;
  logic [5:0] pend_val = 6'd0;
  logic       ovr_en = 1'b0;
  logic [5:0] ovr_val = 6'd0;
  logic [5:0] col_arr [W*H];
  int         n_rd = 0, n_fe = 0, n_hsl = 0, n_vsl = 0, n_act = 0;

  function automatic bit vis(input int p);
    return ((p % HT) < W) && ((p / HT) < H);
  endfunction

  function automatic int idx(input int p);
    return (p / HT) * W + (p % HT);
  endfunction

  function automatic logic [5:0] bar_col(input int h);
    int b;
    b = h / (W / 8);
    return {((b / 4) % 2 == 1) ? 2'b11 : 2'b00,
            ((b / 2) % 2 == 1) ? 2'b11 : 2'b00,
            (b % 2 == 1)       ? 2'b11 : 2'b00};
  endfunction

  function automatic logic [7:0] expd(input logic [1:0] c);
    return 8'(int'(c) * 85);
  endfunction

  function automatic out_t rst_out();
    out_t o;
    o = '0;
    o.hs  = 1'b1;
    o.vs  = 1'b1;
    o.vck = 1'b1;
    return o;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.x = o_buffer_x;  s.y = o_buffer_y;  s.rd = o_buffer_read;
    s.act = o_vga_active;  s.fe = o_frame_end;
    s.r = o_vga_r;  s.g = o_vga_g;  s.b = o_vga_b;
    s.hs = o_vga_hsync;  s.vs = o_vga_vsync;  s.bn = o_vga_blank_n;  s.vck = o_vga_clk;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      if (n_fails > 40) begin
        $display("FAIL too many failures, stopping early");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
      end
    end
  endtask

  // One clock: memory responder, position/time reference model, full output comparison
  task automatic step();
    out_t got, exp;
    int   t, fp, q;
    bit   tick_now;
    logic [5:0] c;
    @(negedge clk);
    cyc++;
    if (!rst_n) k = 0; else k++;
    got  = sample();
    cor  = pend ? pend_val : 6'($urandom);
    pend = 1'b0;
    exp  = rst_out();
    if (!rst_n) begin
      mx = 0;  my = 0;  m_test = 1'b0;
    end else begin
      if (o_buffer_read) begin
        pend     = 1'b1;
        pend_val = ovr_en ? ovr_val : 6'($urandom);
        if (o_buffer_x < 10'(W) && o_buffer_y < 10'(H))
          col_arr[int'(o_buffer_y) * W + int'(o_buffer_x)] = pend_val;
      end
      n_rd  += int'(o_buffer_read);
      n_fe  += int'(o_frame_end);
      n_hsl += int'(!o_vga_hsync);
      n_vsl += int'(!o_vga_vsync);
      n_act += int'(o_vga_active);
      t        = k / D;
      tick_now = (k != 0) && (k % D == 0);
      exp.vck  = (k % D) < (D / 2);
      exp.act  = (t > 0) && vis(t % FT);
      exp.fe   = tick_now && ((t % FT) == H * HT);
      if (tick_now) begin
        fp = (t - 1) % FT;
        if (fp == 0) m_test = test_mode;
        if (vis(fp)) begin
          if (m_test) col_arr[idx(fp)] = bar_col(fp % HT);
          else begin
            exp.rd = 1'b1;  mx = fp % HT;  my = fp / HT;
          end
        end
      end
      exp.x = 10'(mx);
      exp.y = 10'(my);
      if (t >= 2) begin
        q      = (t - 2) % FT;
        exp.bn = vis(q);
        exp.hs = !(((q % HT) >= W + HF) && ((q % HT) < W + HF + HS));
        exp.vs = !(((q / HT) >= H + VF) && ((q / HT) < H + VF + VS));
        if (exp.bn) begin
          c     = col_arr[idx(q)];
          exp.r = expd(c[5:4]);
          exp.g = expd(c[3:2]);
          exp.b = expd(c[1:0]);
        end
      end
    end
    check("cycle_outputs", 64'(got), 64'(exp));
  endtask

  task automatic wait_read(input int x, input int y);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FT * D && !ok; i++) begin
      step();
      if (o_buffer_read && o_buffer_x == 10'(x) && o_buffer_y == 10'(y)) ok = 1'b1;
    end
    check("wait_read_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_fe();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FT * D && !ok; i++) begin
      step();
      if (o_frame_end) ok = 1'b1;
    end
    check("wait_frame_end_seen", 64'(ok), 64'd1);
  endtask

  initial begin
    vec_t tbl [6];
    int   s_cyc, s_rd, s_fe, s_hsl, s_vsl, s_act;
    bit   ok;
    tbl[0] = '{6'b110000, 8'hFF, 8'h00, 8'h00};
    tbl[1] = '{6'b011011, 8'h55, 8'hAA, 8'hFF};
    tbl[2] = '{6'b000000, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{6'b111111, 8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{6'b100110, 8'hAA, 8'h55, 8'hAA};
    tbl[5] = '{6'b001001, 8'h00, 8'hAA, 8'h55};

    repeat (3) step();
    #2 rst_n = 1'b1;

    // One line: W reads in order on row 0, then row 1 starts at x=0
    s_rd = n_rd;
    repeat (HT * D) step();
    check("line0_reads", 64'(n_rd - s_rd), 64'(W));
    ok = 1'b0;
    for (int i = 0; i < 4 * D && !ok; i++) begin
      step();
      if (o_buffer_read) ok = 1'b1;
    end
    check("line1_first_read", {o_buffer_read, o_buffer_y, o_buffer_x}, {1'b1, 10'd1, 10'd0});

    // Colour expansion table at pixel (5,3)
    for (int i = 0; i < 6; i++) begin
      ovr_en  = 1'b1;
      ovr_val = tbl[i].cor;
      wait_read(5, 3);
      repeat (D) step();
      check("tbl_blank_n", 64'(o_vga_blank_n), 64'd1);
      check("tbl_r", 64'(o_vga_r), 64'(tbl[i].r));
      check("tbl_g", 64'(o_vga_g), 64'(tbl[i].g));
      check("tbl_b", 64'(o_vga_b), 64'(tbl[i].b));
    end
    ovr_en = 1'b0;

    // Mid-line asynchronous reset, then restart from pixel (0,0)
    wait_read(7, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 64'(sample()), 64'(rst_out()));
    repeat (3) step();
    #2 rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 * D && !ok; i++) begin
      step();
      if (o_buffer_read) ok = 1'b1;
    end
    check("first_read_after_reset", {o_buffer_read, o_buffer_y, o_buffer_x}, {1'b1, 10'd0, 10'd0});

    // Whole-frame statistics between consecutive frame_end pulses
    wait_fe();
    s_cyc = cyc;  s_rd = n_rd;  s_fe = n_fe;  s_hsl = n_hsl;  s_vsl = n_vsl;  s_act = n_act;
    wait_fe();
    check("frame_period_clk", 64'(cyc - s_cyc), 64'(FT * D));
    check("frame_reads", 64'(n_rd - s_rd), 64'(W * H));
    check("frame_end_clks", 64'(n_fe - s_fe), 64'd1);
    check("hsync_low_clks", 64'(n_hsl - s_hsl), 64'(HS * VT * D));
    check("vsync_low_clks", 64'(n_vsl - s_vsl), 64'(VS * HT * D));
    check("active_clks", 64'(n_act - s_act), 64'(W * H * D));

    // Random phase: random pixel data, occasional resets at random offsets
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 1499) == 0) begin
        #($urandom_range(1, 4)) rst_n = 1'b0;
        repeat ($urandom_range(1, 4)) step();
        #2 rst_n = 1'b1;
      end
`ifdef TEST_PATTERN_EN
      if ($urandom_range(0, 299) == 0) test_mode = ~test_mode;
`endif
    end

`ifdef TEST_PATTERN_EN
    // Colour-bar frame: no buffer reads for the whole frame
    test_mode = 1'b1;
    wait_fe();
    s_rd = n_rd;
    wait_fe();
    check("pattern_frame_reads", 64'(n_rd - s_rd), 64'd0);
    test_mode = 1'b0;
    wait_fe();
    s_rd = n_rd;
    wait_fe();
    check("normal_frame_reads", 64'(n_rd - s_rd), 64'(W * H));
`endif

    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
